// File: rtl/cpu_trace_serializer.sv
// Serialises one CPU write-back record per handshake into the ASCII trace format read by cpu_checker.
// State | meaning: IDLE accept record | CONV time to BCD, one bit per clk | EMIT one char per clk
module cpu_trace_serializer #(
    parameter int          TIME_W    = 14,
    parameter bit          UPPER_HEX = 1'b0,
    parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_reg,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        out_char,
    output logic              out_valid,
    output logic              busy,
    output logic              rec_done
);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_EMIT} state_t;

    state_t              state_q;
    logic                kind_q;
    logic [31:0]         pc_q, addr_q, data_q;
    logic [4:0]          reg_q;
    logic [TIME_W-1:0]   bin_q;
    logic [15:0]         bcd_q;
    logic [3:0]          cnt_q;
    logic [5:0]          idx_q;
    logic [7:0]          out_char_q;
    logic                out_valid_q, rec_done_q;

    logic [13:0] time_ext, time_clamp;
    logic [15:0] bcd_adj, bcd_d;
    logic [5:0]  td, fl, pdat, rel, sub;
    logic [3:0]  tens, ones;
    logic [7:0]  char_d;
    logic        last_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return (UPPER_HEX ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    assign time_ext   = 14'(in_time);
    assign time_clamp = (time_ext > 14'd9999) ? 14'd9999 : time_ext;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        bcd_d = 16'({bcd_adj, bin_q[TIME_W-1]});
    end

    // Field positions move with the number of time and register digits.
    always_comb begin
        char_d = IDLE_CHAR;
        last_d = 1'b0;
        sub    = 6'd0;
        if (bcd_q[15:12] != 4'd0)     td = 6'd4;
        else if (bcd_q[11:8] != 4'd0) td = 6'd3;
        else if (bcd_q[7:4] != 4'd0)  td = 6'd2;
        else                          td = 6'd1;
        if (reg_q >= 5'd30)      begin tens = 4'd3; ones = 4'(reg_q - 5'd30); end
        else if (reg_q >= 5'd20) begin tens = 4'd2; ones = 4'(reg_q - 5'd20); end
        else if (reg_q >= 5'd10) begin tens = 4'd1; ones = 4'(reg_q - 5'd10); end
        else                     begin tens = 4'd0; ones = 4'(reg_q); end
        fl   = kind_q ? 6'd8 : ((tens != 4'd0) ? 6'd2 : 6'd1);
        pdat = td + 6'd12 + fl;
        rel  = idx_q - pdat;
        if (idx_q == 6'd0) begin
            char_d = 8'h5e;
        end else if (idx_q <= td) begin
            sub    = td - idx_q;
            char_d = 8'h30 + {4'h0, 4'(bcd_q >> {sub, 2'b00})};
        end else if (idx_q == td + 6'd1) begin
            char_d = 8'h40;
        end else if (idx_q <= td + 6'd9) begin
            sub    = td + 6'd9 - idx_q;
            char_d = hex_char(4'(pc_q >> {sub, 2'b00}));
        end else if (idx_q == td + 6'd10) begin
            char_d = 8'h3a;
        end else if (idx_q == td + 6'd11) begin
            char_d = kind_q ? 8'h2a : 8'h24;
        end else if (idx_q < pdat) begin
            if (kind_q) begin
                sub    = pdat - 6'd1 - idx_q;
                char_d = hex_char(4'(addr_q >> {sub, 2'b00}));
            end else if (tens != 4'd0 && idx_q == td + 6'd12) begin
                char_d = 8'h30 + {4'h0, tens};
            end else begin
                char_d = 8'h30 + {4'h0, ones};
            end
        end else begin
            case (rel)
                6'd0, 6'd3: char_d = 8'h20;
                6'd1:       char_d = 8'h3c;
                6'd2:       char_d = 8'h3d;
                6'd12: begin
                    char_d = 8'h23;
                    last_d = 1'b1;
                end
                default: begin
                    if (rel < 6'd12) begin
                        sub    = 6'd11 - rel;
                        char_d = hex_char(4'(data_q >> {sub, 2'b00}));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            kind_q      <= 1'b0;
            pc_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            reg_q       <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            out_char_q  <= IDLE_CHAR;
            out_valid_q <= 1'b0;
            rec_done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    out_char_q  <= IDLE_CHAR;
                    out_valid_q <= 1'b0;
                    rec_done_q  <= 1'b0;
                    if (in_valid) begin
                        kind_q  <= in_kind;
                        pc_q    <= in_pc;
                        addr_q  <= in_addr;
                        data_q  <= in_data;
                        reg_q   <= in_reg;
                        bin_q   <= TIME_W'(time_clamp);
                        bcd_q   <= '0;
                        cnt_q   <= 4'(TIME_W - 1);
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd_q <= bcd_d;
                    bin_q <= {bin_q[TIME_W-2:0], 1'b0};
                    if (cnt_q == 4'd0) begin
                        idx_q   <= '0;
                        state_q <= S_EMIT;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_EMIT: begin
                    if (rec_done_q) begin
                        out_char_q  <= IDLE_CHAR;
                        out_valid_q <= 1'b0;
                        rec_done_q  <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        out_char_q  <= char_d;
                        out_valid_q <= 1'b1;
                        rec_done_q  <= last_d;
                        idx_q       <= idx_q + 6'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = ~in_ready;
    assign out_char  = out_char_q;
    assign out_valid = out_valid_q;
    assign rec_done  = rec_done_q;

endmodule

// File: tb/tb_cpu_trace_serializer.sv
// Directed bench for cpu_trace_serializer: lower- and upper-case hex instances share one input stream.
module tb_cpu_trace_serializer;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_kind;
    logic [13:0] in_time;
    logic [31:0] in_pc, in_addr, in_data;
    logic [4:0]  in_reg;
    logic        lo_ready, lo_valid, lo_busy, lo_done;
    logic        up_ready, up_valid, up_busy, up_done;
    logic [7:0]  lo_char, up_char;
    logic        sel_up;
    logic        m_valid, m_done;
    logic [7:0]  m_char;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  cap [64];
    int          cap_len, first_k;
    bit          done_ok, timed_out;

    always #5 clk = ~clk;

    cpu_trace_serializer #(.TIME_W(14), .UPPER_HEX(1'b0), .IDLE_CHAR(8'h00)) u_lo (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(lo_ready), .in_kind(in_kind),
        .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg), .in_addr(in_addr), .in_data(in_data),
        .out_char(lo_char), .out_valid(lo_valid), .busy(lo_busy), .rec_done(lo_done));

    cpu_trace_serializer #(.TIME_W(14), .UPPER_HEX(1'b1), .IDLE_CHAR(8'h00)) u_up (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(up_ready), .in_kind(in_kind),
        .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg), .in_addr(in_addr), .in_data(in_data),
        .out_char(up_char), .out_valid(up_valid), .busy(up_busy), .rec_done(up_done));

    assign m_valid = sel_up ? up_valid : lo_valid;
    assign m_done  = sel_up ? up_done  : lo_done;
    assign m_char  = sel_up ? up_char  : lo_char;

    function automatic int first_diff(input string exp);
        int n;
        n = (cap_len < exp.len()) ? cap_len : exp.len();
        for (int i = 0; i < n; i++) if (cap[i] != exp[i]) return i;
        if (cap_len != exp.len()) return n;
        return -1;
    endfunction

    function automatic string cap_str();
        string s = "";
        for (int i = 0; i < cap_len && i < 64; i++) s = $sformatf("%s%c", s, cap[i]);
        return s;
    endfunction

    task automatic drive(input bit k, input logic [13:0] t, input logic [31:0] pc,
                         input logic [4:0] r, input logic [31:0] a, input logic [31:0] d);
        in_kind = k; in_time = t; in_pc = pc; in_reg = r; in_addr = a; in_data = d;
        in_valid = 1'b1;
    endtask

    // Waits for the transfer edge, then records one full record; k=0 is the sample right after that edge.
    task automatic capture(input bit drop);
        cap_len = 0; first_k = -1; done_ok = 1'b1; timed_out = 1'b1;
        @(posedge clk);
        #1;
        if (drop) begin
            in_valid = 1'b0; in_pc = '1; in_data = '1; in_addr = '1; in_time = '1; in_kind = ~in_kind;
        end
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (m_valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                if (cap_len < 64) cap[cap_len] = m_char;
                cap_len++;
            end else if (first_k >= 0) begin
                done_ok = 1'b0;
            end
            if (m_done !== (m_valid === 1'b1 && m_char == 8'h23)) done_ok = 1'b0;
            if (m_done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0;
        drive(1'b0, 14'd0, 32'h0, 5'd0, 32'h0, 32'h0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({lo_char, lo_valid, lo_done, lo_ready, lo_busy} !== {8'h00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got char=%h valid=%b done=%b ready=%b busy=%b, want 00 0 0 1 0",
                     lo_char, lo_valid, lo_done, lo_ready, lo_busy);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reg_write();
        string exp = "^1024@000030fc:$2 <= 89abcdef#";
        sel_up = 1'b0;
        drive(1'b0, 14'd1024, 32'h000030fc, 5'd2, 32'h0, 32'h89abcdef);
        capture(1'b1);
        vectors++;
        if (first_diff(exp) != -1) begin
            miscompares++;
            $display("FAIL reg_record: got \"%s\" want \"%s\"", cap_str(), exp);
        end
        vectors++;
        if (first_k != 15) begin
            miscompares++;
            $display("FAIL reg_latency: got %0d want 15", first_k);
        end
        vectors++;
        if (!done_ok || timed_out) begin
            miscompares++;
            $display("FAIL reg_rec_done: ok=%0b timeout=%0b want 1 0", done_ok, timed_out);
        end
        vectors++;
        if (lo_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reg_busy_at_hash: got %b want 1", lo_busy);
        end
        @(negedge clk);
        vectors++;
        if ({lo_valid, lo_char, lo_ready, lo_busy, lo_done} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reg_idle_after: got valid=%b char=%h ready=%b busy=%b done=%b, want 0 00 1 0 0",
                     lo_valid, lo_char, lo_ready, lo_busy, lo_done);
        end
    endtask

    task automatic test_mem_write();
        string exp = "^0@00003000:*0000000c <= 00000000#";
        sel_up = 1'b0;
        drive(1'b1, 14'd0, 32'h00003000, 5'd9, 32'h0000000c, 32'h0);
        capture(1'b1);
        vectors++;
        if (first_diff(exp) != -1) begin
            miscompares++;
            $display("FAIL mem_record: got \"%s\" want \"%s\"", cap_str(), exp);
        end
        vectors++;
        if (first_k != 15) begin
            miscompares++;
            $display("FAIL mem_latency: got %0d want 15", first_k);
        end
        vectors++;
        if (!done_ok || timed_out) begin
            miscompares++;
            $display("FAIL mem_rec_done: ok=%0b timeout=%0b want 1 0", done_ok, timed_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        string exp_a = "^9999@00000100:$31 <= 0000001f#";
        string exp_b = "^7@12345678:$10 <= cafef00d#";
        sel_up = 1'b0;
        drive(1'b0, 14'd16383, 32'h00000100, 5'd31, 32'h0, 32'h0000001f);
        fork
            capture(1'b0);
            begin
                @(posedge clk);
                #2;
                drive(1'b0, 14'd7, 32'h12345678, 5'd10, 32'hffffffff, 32'hcafef00d);
            end
        join
        vectors++;
        if (first_diff(exp_a) != -1) begin
            miscompares++;
            $display("FAIL b2b_first: got \"%s\" want \"%s\"", cap_str(), exp_a);
        end
        vectors++;
        if (!done_ok || timed_out) begin
            miscompares++;
            $display("FAIL b2b_first_done: ok=%0b timeout=%0b want 1 0", done_ok, timed_out);
        end
        @(negedge clk);
        vectors++;
        if ({lo_valid, lo_char, lo_ready} !== {1'b0, 8'h00, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_gap: got valid=%b char=%h ready=%b want 0 00 1", lo_valid, lo_char, lo_ready);
        end
        capture(1'b1);
        vectors++;
        if (first_diff(exp_b) != -1) begin
            miscompares++;
            $display("FAIL b2b_second: got \"%s\" want \"%s\"", cap_str(), exp_b);
        end
        vectors++;
        if (first_k != 15) begin
            miscompares++;
            $display("FAIL b2b_second_latency: got %0d want 15", first_k);
        end
        @(negedge clk);
    endtask

    task automatic test_upper_hex();
        string exp = "^305@ABCDEF01:*0000FADE <= DEADBEEF#";
        sel_up = 1'b1;
        drive(1'b1, 14'd305, 32'habcdef01, 5'd0, 32'h0000fade, 32'hdeadbeef);
        capture(1'b1);
        vectors++;
        if (first_diff(exp) != -1) begin
            miscompares++;
            $display("FAIL upper_record: got \"%s\" want \"%s\"", cap_str(), exp);
        end
        vectors++;
        if (!done_ok || timed_out) begin
            miscompares++;
            $display("FAIL upper_rec_done: ok=%0b timeout=%0b want 1 0", done_ok, timed_out);
        end
        sel_up = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_emit();
        string exp = "^12@0";
        bit    stray;
        int    diff;
        sel_up = 1'b0;
        drive(1'b0, 14'd12, 32'h0, 5'd0, 32'h0, 32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        cap_len = 0;
        for (int k = 0; k < 60 && cap_len < 5; k++) begin
            @(negedge clk);
            if (lo_valid === 1'b1) begin
                cap[cap_len] = lo_char;
                cap_len++;
            end
        end
        diff = first_diff(exp);
        vectors++;
        if (diff != -1) begin
            miscompares++;
            $display("FAIL abort_prefix: got \"%s\" want \"%s\"", cap_str(), exp);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({lo_valid, lo_char, lo_ready, lo_busy, lo_done} !== {1'b0, 8'h00, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_async: got valid=%b char=%h ready=%b busy=%b done=%b, want 0 00 1 0 0",
                     lo_valid, lo_char, lo_ready, lo_busy, lo_done);
        end
        @(negedge clk);
        reset = 1'b1;
        stray = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (lo_valid !== 1'b0 || lo_char !== 8'h00 || lo_done !== 1'b0 || lo_ready !== 1'b1) stray = 1'b1;
        end
        vectors++;
        if (stray) begin
            miscompares++;
            $display("FAIL abort_quiet: got stray output after reset, want idle stream");
        end
    endtask

    initial begin
        sel_up = 1'b0;
        test_reset();
        test_reg_write();
        test_mem_write();
        test_back_to_back();
        test_upper_hex();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
